// File: rtl/internet_rx_parser.sv
// internet_rx_parser
// IP receive layer. When the Ethernet layer signals a new frame, the 20-byte
// IPv4 header is read byte by byte from the shared frame RAM. The header is then
// validated: version/IHL, destination address, fragmentation, length and checksum.
// A good datagram is announced to the transport layer and held until it is
// acknowledged. A bad one is counted and dropped. In both cases the RAM buffer
// is then handed back to Ethernet with a one-cycle frameRelease pulse.
module internet_rx_parser #(
    parameter logic [31:0] DEVICE_IP = 32'h0a0105dd,
    parameter logic [7:0]  HDR_BASE  = 8'h0E
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        newFrame,
    input  logic [10:0] frameLen,
    output logic        rdRAM,
    output logic [7:0]  rdAddr,
    input  logic [7:0]  rdData,
    input  logic        complete,
    output logic        newDatagram,
    input  logic        datagramAck,
    output logic [7:0]  protocolOut,
    output logic [31:0] sourceIP,
    output logic [15:0] datagramSize,
    output logic        frameRelease,
    output logic [7:0]  dropCount
);

    typedef enum logic [2:0] {
        IDLE,
        RDHDR,
        CHECK,
        DELIVER,
        DROP,
        RELEASE
    } state_t;

    state_t      state;
    state_t      nextState;

    logic [4:0]  cnt;
    logic        gap;
    logic [10:0] lenLatch;
    logic [16:0] acc;
    logic [7:0]  hiByte;

    logic [7:0]  verIhl;
    logic [15:0] totLen;
    logic [7:0]  fragHi;
    logic [7:0]  fragLo;
    logic [7:0]  proto;
    logic [31:0] srcIp;
    logic [31:0] dstIp;

    logic        byteDone;
    logic [15:0] csumFolded;
    logic        hdrOk;

    // A header byte is taken only while a read is actually outstanding.
    // The gap cycle after each completion is excluded.
    assign byteDone   = (state == RDHDR) && !gap && complete;

    // The final end-around fold of the checksum accumulator.
    assign csumFolded = acc[15:0] + {15'b0, acc[16]};

    // All header acceptance rules are combined here. DF (byte6 bit6) is deliberately not examined.
    assign hdrOk = (verIhl == 8'h45)
                && (dstIp == DEVICE_IP)
                && !fragHi[5]
                && (fragHi[4:0] == 5'd0)
                && (fragLo == 8'd0)
                && (totLen >= 16'd20)
                && (totLen <= {5'b0, lenLatch})
                && (csumFolded == 16'hFFFF);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state selection and the state-decoded handshake outputs
    always_comb begin
        nextState    = state;
        rdRAM        = 1'b0;
        rdAddr       = 8'h00;
        newDatagram  = 1'b0;
        frameRelease = 1'b0;
        case (state)
            IDLE: begin
                if (newFrame) begin
                    nextState = RDHDR;
                end
            end
            RDHDR: begin
                rdRAM  = !gap;
                rdAddr = HDR_BASE + {3'b0, cnt};
                if (byteDone && (cnt == 5'd19)) begin
                    nextState = CHECK;
                end
            end
            CHECK: begin
                nextState = hdrOk ? DELIVER : DROP;
            end
            DELIVER: begin
                newDatagram = 1'b1;
                if (datagramAck) begin
                    nextState = RELEASE;
                end
            end
            DROP: begin
                nextState = RELEASE;
            end
            RELEASE: begin
                frameRelease = 1'b1;
                nextState    = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Byte counter, inter-read gap flag and the latched frame length
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt      <= 5'd0;
            gap      <= 1'b0;
            lenLatch <= 11'd0;
        end else begin
            gap <= byteDone;
            if ((state == IDLE) && newFrame) begin
                cnt      <= 5'd0;
                lenLatch <= frameLen;
            end else if (byteDone) begin
                cnt <= cnt + 5'd1;
            end
        end
    end

    // Capture the header fields needed for validation and delivery
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            verIhl <= 8'h00;
            totLen <= 16'h0000;
            fragHi <= 8'h00;
            fragLo <= 8'h00;
            proto  <= 8'h00;
            srcIp  <= 32'h0;
            dstIp  <= 32'h0;
        end else if (byteDone) begin
            case (cnt)
                5'd0:    verIhl        <= rdData;
                5'd2:    totLen[15:8]  <= rdData;
                5'd3:    totLen[7:0]   <= rdData;
                5'd6:    fragHi        <= rdData;
                5'd7:    fragLo        <= rdData;
                5'd9:    proto         <= rdData;
                5'd12:   srcIp[31:24]  <= rdData;
                5'd13:   srcIp[23:16]  <= rdData;
                5'd14:   srcIp[15:8]   <= rdData;
                5'd15:   srcIp[7:0]    <= rdData;
                5'd16:   dstIp[31:24]  <= rdData;
                5'd17:   dstIp[23:16]  <= rdData;
                5'd18:   dstIp[15:8]   <= rdData;
                5'd19:   dstIp[7:0]    <= rdData;
                default: ;
            endcase
        end
    end

    // Ones'-complement checksum. Even bytes are held as the high half. Each
    // completed word is then added, and the previous carry is folded back in.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc    <= 17'd0;
            hiByte <= 8'h00;
        end else if ((state == IDLE) && newFrame) begin
            acc    <= 17'd0;
            hiByte <= 8'h00;
        end else if (byteDone) begin
            if (!cnt[0]) begin
                hiByte <= rdData;
            end else begin
                acc <= {1'b0, acc[15:0]} + {16'b0, acc[16]} + {1'b0, hiByte, rdData};
            end
        end
    end

    // Delivered datagram description. It is updated only by a header that passes,
    // so dropped frames leave the last good values in place.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            protocolOut  <= 8'h00;
            sourceIP     <= 32'h0;
            datagramSize <= 16'h0000;
        end else if ((state == CHECK) && hdrOk) begin
            protocolOut  <= proto;
            sourceIP     <= srcIp;
            datagramSize <= totLen - 16'd20;
        end
    end

    // Saturating count of rejected frames
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dropCount <= 8'h00;
        end else if ((state == DROP) && (dropCount != 8'hFF)) begin
            dropCount <= dropCount + 8'd1;
        end
    end

endmodule
